// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the processor FSM
// and the host readout port. One access at a time, round-robin on ties,
// fixed read latency absorbed here so requesters only see gnt/ack pulses.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    // Requester identity: CPU = 0, HOST = 1
    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                owner_reg, owner_next;
    logic                last_owner_reg, last_owner_next;
    logic [LAT_W-1:0]    lat_cnt_reg, lat_cnt_next;
    logic                cpu_gnt_reg, cpu_gnt_next;
    logic                host_gnt_reg, host_gnt_next;
    logic                cpu_ack_reg, cpu_ack_next;
    logic                host_ack_reg, host_ack_next;
    logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
    logic                mem_en_reg, mem_en_next;
    logic                mem_ren_reg, mem_ren_next;
    logic                mem_wen_reg, mem_wen_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_din_reg, mem_din_next;

    logic                any_req;
    logic                win;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // Winner selection: a lone request wins; on a tie the side that did not
    // own the previous access wins.
    always_comb begin
        any_req = cpu_req | host_req;
        if (cpu_req && host_req) begin
            win = ~last_owner_reg;
        end else if (cpu_req) begin
            win = OWN_CPU;
        end else begin
            win = OWN_HOST;
        end
        if (win == OWN_CPU) begin
            win_we    = cpu_we;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
        end else begin
            win_we    = host_we;
            win_addr  = host_addr;
            win_wdata = host_wdata;
        end
    end

    // Next-state and next-output logic; everything defaults to hold, pulses to 0
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        lat_cnt_next    = lat_cnt_reg;
        cpu_gnt_next    = 1'b0;
        host_gnt_next   = 1'b0;
        cpu_ack_next    = 1'b0;
        host_ack_next   = 1'b0;
        rd_data_next    = rd_data_reg;
        mem_en_next     = mem_en_reg;
        mem_ren_next    = mem_ren_reg;
        mem_wen_next    = mem_wen_reg;
        mem_addr_next   = mem_addr_reg;
        mem_din_next    = mem_din_reg;

        case (state_reg)
            IDLE, RESP: begin
                // Arbitration edge; the RESP exit edge allows back-to-back accesses
                if (any_req) begin
                    mem_addr_next   = win_addr;
                    mem_din_next    = win_wdata;
                    mem_en_next     = 1'b1;
                    mem_ren_next    = ~win_we;
                    mem_wen_next    = win_we;
                    cpu_gnt_next    = (win == OWN_CPU);
                    host_gnt_next   = (win == OWN_HOST);
                    owner_next      = win;
                    last_owner_next = win;
                    lat_cnt_next    = LAT_ONE;
                    state_next      = win_we ? WR : RD_WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    rd_data_next  = mem_dout;
                    mem_en_next   = 1'b0;
                    mem_ren_next  = 1'b0;
                    cpu_ack_next  = (owner_reg == OWN_CPU);
                    host_ack_next = (owner_reg == OWN_HOST);
                    state_next    = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_ONE;
                end
            end
            WR: begin
                // Write strobe is a single cycle
                mem_en_next   = 1'b0;
                mem_wen_next  = 1'b0;
                cpu_ack_next  = (owner_reg == OWN_CPU);
                host_ack_next = (owner_reg == OWN_HOST);
                state_next    = RESP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_CPU;
            last_owner_reg <= OWN_HOST;
            lat_cnt_reg    <= '0;
            cpu_gnt_reg    <= 1'b0;
            host_gnt_reg   <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            host_ack_reg   <= 1'b0;
            rd_data_reg    <= '0;
            mem_en_reg     <= 1'b0;
            mem_ren_reg    <= 1'b0;
            mem_wen_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            lat_cnt_reg    <= lat_cnt_next;
            cpu_gnt_reg    <= cpu_gnt_next;
            host_gnt_reg   <= host_gnt_next;
            cpu_ack_reg    <= cpu_ack_next;
            host_ack_reg   <= host_ack_next;
            rd_data_reg    <= rd_data_next;
            mem_en_reg     <= mem_en_next;
            mem_ren_reg    <= mem_ren_next;
            mem_wen_reg    <= mem_wen_next;
            mem_addr_reg   <= mem_addr_next;
            mem_din_reg    <= mem_din_next;
        end
    end

    assign cpu_gnt  = cpu_gnt_reg;
    assign host_gnt = host_gnt_reg;
    assign cpu_ack  = cpu_ack_reg;
    assign host_ack = host_ack_reg;
    assign rd_data  = rd_data_reg;
    assign busy     = (state_reg != IDLE);
    assign mem_en   = mem_en_reg;
    assign mem_ren  = mem_ren_reg;
    assign mem_wen  = mem_wen_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_din  = mem_din_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus
// hand-written sequences for tie fairness, streaming and mid-access reset.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_ack;
    logic              host_req = 1'b0, host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_gnt, host_ack;
    logic [DATA_W-1:0] rd_data;
    logic              busy, mem_en, mem_ren, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_ack(host_ack),
        .rd_data(rd_data), .busy(busy),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: data only valid in the last cycle of the read latency window
    logic [DATA_W-1:0] mem [0:255];
    int ren_cnt = 0;
    always @(posedge clk) begin
        ren_cnt <= mem_ren ? ren_cnt + 1 : 0;
        if (mem_en && mem_wen) mem[mem_addr[7:0]] <= mem_din;
    end
    assign mem_dout = (mem_ren && ren_cnt == READ_LAT - 1) ? mem[mem_addr[7:0]] : 32'hBADBAD00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor
    int cpu_gnt_cnt = 0, cpu_ack_cnt = 0, host_gnt_cnt = 0, host_ack_cnt = 0;
    logic              prev_en = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ren_wen_excl", 64'(mem_ren & mem_wen), 64'd0);
            chk("pulse_overlap", 64'({cpu_gnt & cpu_ack, host_gnt & host_ack,
                (cpu_gnt | cpu_ack) & (host_gnt | host_ack)}), 64'd0);
            if (prev_en && mem_en) chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
            if (cpu_gnt)  cpu_gnt_cnt++;
            if (cpu_ack)  cpu_ack_cnt++;
            if (host_gnt) host_gnt_cnt++;
            if (host_ack) host_ack_cnt++;
        end
        prev_en   = mem_en;
        prev_addr = mem_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at %0t", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        who;     // 0 = CPU, 1 = HOST
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;  // rd_data expected in the ack cycle
        int          exp_ack; // cycle of ack counted from accept edge
    } vec_t;

    vec_t tbl [9];

    task automatic drive(input vec_t v);
        if (v.who == 1'b0) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
        end
    endtask

    int n;
    int gcyc [8];
    int gwho [8];
    int acyc [8];
    logic [31:0] ardat [8];
    int gcount, acount;
    int ack_before;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        #1;
        mem[4] <= 32'hDEADBEEF;

        tbl[0] = '{1'b0, 1'b0, 16'h0004, 32'h0,        32'hDEADBEEF, 4};
        tbl[1] = '{1'b1, 1'b1, 16'h0010, 32'h12345678, 32'hDEADBEEF, 2};
        tbl[2] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'h12345678, 4};
        tbl[3] = '{1'b1, 1'b0, 16'h0004, 32'h0,        32'hDEADBEEF, 4};
        tbl[4] = '{1'b0, 1'b1, 16'h0020, 32'hA5A50001, 32'hDEADBEEF, 2};
        tbl[5] = '{1'b1, 1'b0, 16'h0020, 32'h0,        32'hA5A50001, 4};
        tbl[6] = '{1'b0, 1'b0, 16'h0030, 32'h0,        32'hC0DE0030, 4};
        tbl[7] = '{1'b1, 1'b1, 16'h0004, 32'h0BADF00D, 32'hC0DE0030, 2};
        tbl[8] = '{1'b0, 1'b0, 16'h0004, 32'h0,        32'h0BADF00D, 4};

        // Reset state
        #2;
        chk("reset_ctrl", 64'({cpu_gnt, cpu_ack, host_gnt, host_ack, busy, mem_en, mem_ren, mem_wen}), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_din", 64'(mem_din), 64'd0);
        chk("reset_rd", 64'(rd_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);

        // Table of single-requester transactions, chained back to back
        drive(tbl[0]);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            $display("txn %0d who=%0d we=%0d addr=%h", i, tbl[i].who, tbl[i].we, tbl[i].addr);
            chk("tbl_cpu_gnt", 64'(cpu_gnt), 64'(tbl[i].who == 1'b0));
            chk("tbl_host_gnt", 64'(host_gnt), 64'(tbl[i].who == 1'b1));
            chk("tbl_ren_c1", 64'(mem_ren), 64'(!tbl[i].we));
            chk("tbl_wen_c1", 64'(mem_wen), 64'(tbl[i].we));
            chk("tbl_addr", 64'(mem_addr), 64'(tbl[i].addr));
            cpu_req = 1'b0; host_req = 1'b0;
            n = 1;
            while (!(cpu_ack || host_ack) && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (!(cpu_ack || host_ack)) begin
                    chk("tbl_ren_wait", 64'(mem_ren), 64'(!tbl[i].we && n <= READ_LAT));
                    chk("tbl_wen_wait", 64'(mem_wen), 64'd0);
                end
            end
            chk("tbl_ack_cycle", 64'(n), 64'(tbl[i].exp_ack));
            chk("tbl_cpu_ack", 64'(cpu_ack), 64'(tbl[i].who == 1'b0));
            chk("tbl_host_ack", 64'(host_ack), 64'(tbl[i].who == 1'b1));
            chk("tbl_rd_data", 64'(rd_data), 64'(tbl[i].exp_rd));
            chk("tbl_ack_ctrl", 64'({mem_en, mem_ren, mem_wen}), 64'd0);
            if (i < 8) drive(tbl[i + 1]);
        end
        @(posedge clk); #1;
        chk("tbl_end_idle", 64'(busy), 64'd0);

        // Tie fairness from reset: both hold read requests continuously
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        gcount = 0; acount = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if ((cpu_gnt || host_gnt) && gcount < 8) begin
                gcyc[gcount] = c; gwho[gcount] = host_gnt ? 1 : 0; gcount++;
            end
            if ((cpu_ack || host_ack) && acount < 8) begin
                acyc[acount] = c; ardat[acount] = rd_data; acount++;
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        chk("tie_gnt_count", 64'(gcount), 64'd4);
        chk("tie_ack_count", 64'(acount), 64'd4);
        for (int k = 0; k < 4 && k < gcount && k < acount; k++) begin
            $display("tie grant %0d who=%0d cycle=%0d ack=%0d rd=%h", k, gwho[k], gcyc[k], acyc[k], ardat[k]);
            chk("tie_gnt_cycle", 64'(gcyc[k]), 64'(1 + 4 * k));
            chk("tie_gnt_who", 64'(gwho[k]), 64'(k % 2));
            chk("tie_ack_cycle", 64'(acyc[k]), 64'(4 + 4 * k));
            chk("tie_rd_data", 64'(ardat[k]), (k % 2 == 0) ? 64'h12345678 : 64'hA5A50001);
        end
        @(posedge clk); #1;
        chk("tie_end_idle", 64'(busy), 64'd0);

        // Host streaming reads, CPU idle; last owner is HOST
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030;
        gcount = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            chk("stream_no_cpu", 64'(cpu_gnt), 64'd0);
            if (host_gnt && gcount < 8) begin
                gcyc[gcount] = c; gcount++;
                if (gcount == 3) host_req = 1'b0;
            end
            if (host_ack) begin
                $display("stream ack cycle=%0d rd=%h", c, rd_data);
                chk("stream_rd", 64'(rd_data), 64'hC0DE0030);
            end
        end
        chk("stream_gnt_count", 64'(gcount), 64'd3);
        for (int k = 0; k < 3 && k < gcount; k++)
            chk("stream_gnt_cycle", 64'(gcyc[k]), 64'(1 + 4 * k));
        @(posedge clk); #1;
        chk("stream_end_idle", 64'(busy), 64'd0);

        // Reset mid-read: lat_cnt=2 in the second cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
        @(posedge clk); #1;
        chk("rst_mid_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ren", 64'(mem_ren), 64'd1);
        ack_before = cpu_ack_cnt;
        rst_n = 1'b0;
        #1;
        $display("mid-read reset applied at %0t", $time);
        chk("rst_mid_ctrl", 64'({cpu_gnt, cpu_ack, host_gnt, host_ack, busy, mem_en, mem_ren, mem_wen}), 64'd0);
        chk("rst_mid_addr", 64'(mem_addr), 64'd0);
        chk("rst_mid_rd", 64'(rd_data), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_after_busy", 64'(busy), 64'd0);
            chk("rst_after_ack", 64'(cpu_ack), 64'd0);
        end
        chk("rst_no_ack", 64'(cpu_ack_cnt), 64'(ack_before));

        // CPU read after reset
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
        @(posedge clk); #1;
        chk("post_rst_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 1'b0;
        n = 1;
        while (!cpu_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        $display("post-reset read ack cycle=%0d rd=%h", n, rd_data);
        chk("post_rst_ack_cycle", 64'(n), 64'd4);
        chk("post_rst_rd", 64'(rd_data), 64'h0BADF00D);
        @(posedge clk); #1;

        // One ack per gnt, except the CPU read dropped by reset
        chk("cpu_gnt_ack_pair", 64'(cpu_gnt_cnt - cpu_ack_cnt), 64'd1);
        chk("host_gnt_ack_pair", 64'(host_gnt_cnt - host_ack_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port instruction/data memory (MemReadWrite). It lets the processor control FSM and the host/inference readout port share one memory. It grants one access at a time with round-robin fairness, drives the memory enables, address and write data, and waits out the fixed read latency. The processor FSM no longer needs hand-counted wait states.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- READ_LAT, 3, cycles from mem_en/mem_ren rising to mem_dout valid; ≥1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  processor request, level, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address
- cpu_wdata  in  DATA_W  processor write data
- cpu_gnt  out  1  one-cycle pulse: processor request accepted
- cpu_ack  out  1  one-cycle pulse: processor access complete (rd_data valid if read)
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same rules as cpu_*
- host_gnt, host_ack  out  1  host grant / completion pulses
- rd_data  out  DATA_W  captured read data, shared; valid in the ack cycle, held until the next read capture
- busy  out  1  high whenever state ≠ IDLE
- mem_en, mem_ren, mem_wen  out  1  memory controls
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data

## Operation
- States: IDLE, RD_WAIT, WR, RESP. Registers: state, owner (CPU/HOST), last_owner, lat_cnt (width clog2(READ_LAT+1)).
- Arbitration edges: any rising edge with state ∈ {IDLE, RESP}. No other edge samples req.
- Winner selection:
  - only one req high → that requester wins.
  - both high → the requester ≠ last_owner wins.
  - none high → go to IDLE.
- On an accept edge:
  - latch addr/we/wdata into mem_addr/mem_wen/mem_din.
  - set mem_en=1, mem_ren=~we, mem_wen=we.
  - pulse the winner's gnt for the following cycle.
  - owner ← winner, last_owner ← winner, lat_cnt ← 1.
  - go to RD_WAIT (read) or WR (write).
- RD_WAIT:
  - lat_cnt increments each edge.
  - at the edge where lat_cnt = READ_LAT: rd_data ← mem_dout; mem_en, mem_ren ← 0; go to RESP.
- WR: mem_wen high for exactly one cycle; next edge mem_en, mem_wen ← 0; go to RESP.
- RESP: owner's ack high for exactly this cycle. The RESP exit edge is also an arbitration edge, so back-to-back accesses need no idle cycle.
- Requester rule:
  - keep req and fields stable until gnt is seen.
  - a req still high at the next arbitration edge is a new transaction.
  - req changes outside arbitration edges are ignored.
- mem_addr/mem_din hold stable for the whole access; mem_ren and mem_wen are never both 1.

## Timing
- Reset (asynchronous, immediate): state=IDLE, last_owner=HOST (CPU wins first tie), lat_cnt=0. All outputs 0: gnt, ack, rd_data, busy, mem_en/ren/wen, mem_addr, mem_din.
- Read, accepted at edge 0:
  - gnt is cycle 1; mem_en/ren are cycles 1..READ_LAT.
  - mem_dout is sampled at edge READ_LAT; ack is cycle READ_LAT+1.
  - next accept is possible at edge READ_LAT+1.
  - READ_LAT=3 → 4 cycles per read.
- Write, accepted at edge 0: gnt and mem_wen are cycle 1; ack is cycle 2; next accept at edge 2.
- gnt and ack of the same requester never overlap; CPU and host pulses never overlap.
- Reset asserted mid-access: transaction dropped, no ack, memory controls low immediately. A write in its WR cycle may or may not land in memory.
- READ_LAT=1: RD_WAIT lasts one cycle; data is captured at edge 1.

## Test plan
- Reset: rst_n=0 mid-read (RD_WAIT, lat_cnt=2) → all outputs 0 immediately, no cpu_ack. After release, busy=0 until the next req.
- CPU read: addr 0x0004, mem returns 0xDEADBEEF after 3 cycles → cpu_gnt cycle 1, mem_ren cycles 1–3, cpu_ack with rd_data=0xDEADBEEF in cycle 4.
- Host write then CPU read back: host write 0x0010=0x12345678 (host_ack cycle 2), then CPU read 0x0010 → rd_data=0x12345678, no idle cycle between the transactions.
- Tie fairness: cpu_req and host_req asserted together from reset, each re-requesting immediately after its own gnt → grant order CPU, HOST, CPU, HOST; every access completes in 4 cycles.
- Single requester streaming: host_req continuously high for 3 reads with CPU idle → three host_gnt; host never blocked by last_owner.
- Protocol checks: mem_ren&mem_wen never 1; mem_addr stable while mem_en=1; exactly one ack per gnt.
